pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  rising-edge clock for all state; only clock of the block.
REQ-002 SHALL have port: reset  in  1  synchronous active-high reset, sampled only on posedge clk.
REQ-003 SHALL have ports: rn_id, rm_id, rd_id  in  4 each  ID-stage source registers; use_rn, use_rm, use_rd  in  1 each  source-valid flags (use_rd = store data).
REQ-004 SHALL have ports: rd_ex, rd_mem, rd_wb  in  4 each; rf_en_ex, rf_en_mem, rf_en_wb  in  1 each  destination-register write enables per stage.
REQ-005 SHALL have port: load_ex  in  1  EX-stage instruction is a load.
REQ-006 SHALL have ports: branch_taken_id  in  1  ID-stage branch resolved taken; hold_req  in  1  external freeze request.
REQ-007 SHALL have ports: pc_le, ifid_le  out  1 each  PC and IF/ID load enables; nop_sel  out  1  CU mux select, 1 = inject all-zero control bubble into ID/EX.
REQ-008 SHALL have ports: fwd_a, fwd_b, fwd_c  out  2 each  operand source for Rn, Rm, Rd.
REQ-009 SHALL have ports: stall_cnt, flush_cnt  out  16 each  performance counters.

Function
REQ-010 SHALL implement FSM states RUN, LDSTALL, BFLUSH; control outputs are combinational from state and inputs (Mealy).
REQ-011 SHALL define load_use = load_ex & rf_en_ex & rd_ex != 15 & ((use_rn & rn_id==rd_ex) | (use_rm & rm_id==rd_ex) | (use_rd & rd_id==rd_ex)).
REQ-012 SHALL give priority hold_req > load_use > branch_taken_id in RUN.
REQ-013 SHALL, when hold_req=1 in any state: pc_le=0, ifid_le=0, nop_sel=0, state unchanged, no counter change.
REQ-014 SHALL, in RUN with load_use: pc_le=0, ifid_le=0, nop_sel=1, next state LDSTALL; branch_taken_id ignored that cycle.
REQ-015 SHALL, in RUN with branch_taken_id and no load_use: pc_le=1, ifid_le=1, nop_sel=0, next state BFLUSH.
REQ-016 SHALL, in LDSTALL: pc_le=1, ifid_le=1, nop_sel=0, no load_use evaluation; next state BFLUSH if branch_taken_id else RUN.
REQ-017 SHALL, in BFLUSH: pc_le=1, ifid_le=1, nop_sel=1 (squash wrong-path instruction), branch_taken_id and load_use ignored, next state RUN.
REQ-018 SHALL, in RUN with no event: pc_le=1, ifid_le=1, nop_sel=0.
REQ-019 SHALL encode fwd_x: 00 register file, 01 EX result, 10 MEM result, 11 WB result; priority EX > MEM > WB; match requires use flag, stage rf_en, equal register number, register != 15.
REQ-020 SHALL not select EX (01) when load_ex=1; falls to MEM/WB/regfile match.
REQ-021 SHALL increment stall_cnt on each LDSTALL entry and flush_cnt on each BFLUSH entry; both saturate at 16'hFFFF.

Reset
REQ-022 SHALL on reset: state=RUN, stall_cnt=0, flush_cnt=0; outputs during reset cycle pc_le=1, ifid_le=1, nop_sel=0, fwd_*=00.
REQ-023 SHALL abort LDSTALL/BFLUSH on reset mid-operation with no pending bubble afterwards.

Configuration
REQ-024 SHALL gate counters with macro HAZ_PERF_CNT_EN: defined -> REQ-021 behaviour; undefined -> no counter flops, stall_cnt and flush_cnt tied to 16'h0000, ports retained.

Structure
REQ-025 SHALL place FSM state enum, fwd encodings (FWD_RF/EX/MEM/WB) and REG_PC=4'd15 in shared package ppu_pkg.
REQ-026 SHALL use sub-module fwd_select (one operand priority match), instantiated three times for Rn, Rm, Rd.

Verification
REQ-027 SHALL cover: load_ex=1, rd_ex=3, rf_en_ex=1, rn_id=3, use_rn=1 -> cycle0 pc_le=0, ifid_le=0, nop_sel=1; cycle1 LDSTALL all enables 1, fwd_a=10 when rd_mem=3; stall_cnt=1.
REQ-028 SHALL cover: branch_taken_id=1 in RUN -> next cycle nop_sel=1, pc_le=1; following cycle RUN; flush_cnt=1.
REQ-029 SHALL cover: rd_ex=rd_mem=rd_wb=5 all rf_en=1, rm_id=5, use_rm=1, load_ex=0 -> fwd_b=01; rf_en_ex=0 -> 10; rd_id=15 use_rd=1 -> fwd_c=00.
REQ-030 SHALL cover: load_use and branch_taken_id same cycle -> LDSTALL first, branch honoured next cycle into BFLUSH; hold_req=1 during LDSTALL freezes state with all enables 0.
REQ-031 SHALL cover: reset asserted while in BFLUSH -> next cycle state RUN, nop_sel=0, counters 0; with HAZ_PERF_CNT_EN undefined counters read 0 after 10 stalls.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared types and constants for the pipeline hazard control unit:
// FSM state enum, operand-forwarding select encodings and the PC register number.
package ppu_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_BFLUSH  = 2'd2
  } haz_state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_e;

  localparam logic [3:0] REG_PC = 4'd15;

  // A pipeline stage can supply an operand only when it really writes a
  // general register (never the PC) that the ID instruction actually reads.
  function automatic logic reg_match(
    input logic       use_src,
    input logic       stage_en,
    input logic [3:0] src,
    input logic [3:0] dst
  );
    return use_src & stage_en & (src == dst) & (dst != REG_PC);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Forwarding select for one ID-stage source operand: EX > MEM > WB > register file.
// A load in EX cannot forward its result yet, so it falls through to older stages.
module fwd_select
  import ppu_pkg::*;
(
  input  logic [3:0] i_src,
  input  logic       i_use,
  input  logic [3:0] i_rd_ex,
  input  logic       i_rf_en_ex,
  input  logic       i_load_ex,
  input  logic [3:0] i_rd_mem,
  input  logic       i_rf_en_mem,
  input  logic [3:0] i_rd_wb,
  input  logic       i_rf_en_wb,
  output logic [1:0] o_fwd
);

  logic w_hit_ex;
  logic w_hit_mem;
  logic w_hit_wb;

  assign w_hit_ex  = reg_match(i_use, i_rf_en_ex, i_src, i_rd_ex) & ~i_load_ex;
  assign w_hit_mem = reg_match(i_use, i_rf_en_mem, i_src, i_rd_mem);
  assign w_hit_wb  = reg_match(i_use, i_rf_en_wb, i_src, i_rd_wb);

  always_comb begin
    o_fwd = FWD_RF;
    if (w_hit_ex)       o_fwd = FWD_EX;
    else if (w_hit_mem) o_fwd = FWD_MEM;
    else if (w_hit_wb)  o_fwd = FWD_WB;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard control: load-use stall, taken-branch flush, freeze and operand forwarding.
// Optional performance counters are built only when HAZ_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
  import ppu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  rn_id,
  input  logic [3:0]  rm_id,
  input  logic [3:0]  rd_id,
  input  logic        use_rn,
  input  logic        use_rm,
  input  logic        use_rd,
  input  logic [3:0]  rd_ex,
  input  logic [3:0]  rd_mem,
  input  logic [3:0]  rd_wb,
  input  logic        rf_en_ex,
  input  logic        rf_en_mem,
  input  logic        rf_en_wb,
  input  logic        load_ex,
  input  logic        branch_taken_id,
  input  logic        hold_req,
  output logic        pc_le,
  output logic        ifid_le,
  output logic        nop_sel,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [1:0]  fwd_c,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  haz_state_e r_state;
  haz_state_e w_next;
  logic       w_load_use;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic [1:0] w_fwd_c;

  assign w_load_use = load_ex & rf_en_ex & (rd_ex != REG_PC) &
                      ((use_rn & (rn_id == rd_ex)) |
                       (use_rm & (rm_id == rd_ex)) |
                       (use_rd & (rd_id == rd_ex)));

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!hold_req) begin
      case (r_state)
        ST_RUN: begin
          if (w_load_use)           w_next = ST_LDSTALL;
          else if (branch_taken_id) w_next = ST_BFLUSH;
        end
        ST_LDSTALL: w_next = branch_taken_id ? ST_BFLUSH : ST_RUN;
        ST_BFLUSH:  w_next = ST_RUN;
        default:    w_next = ST_RUN;
      endcase
    end
  end

  // Reset forces the free-running defaults so no bubble leaks out of an aborted stall/flush.
  always_comb begin
    pc_le   = 1'b1;
    ifid_le = 1'b1;
    nop_sel = 1'b0;
    if (!reset) begin
      if (hold_req) begin
        pc_le   = 1'b0;
        ifid_le = 1'b0;
      end else begin
        case (r_state)
          ST_RUN: begin
            if (w_load_use) begin
              pc_le   = 1'b0;
              ifid_le = 1'b0;
              nop_sel = 1'b1;
            end
          end
          ST_LDSTALL: nop_sel = 1'b0;
          ST_BFLUSH:  nop_sel = 1'b1;
          default:    nop_sel = 1'b0;
        endcase
      end
    end
  end

  fwd_select u_fwd_rn (
    .i_src       (rn_id),
    .i_use       (use_rn),
    .i_rd_ex     (rd_ex),
    .i_rf_en_ex  (rf_en_ex),
    .i_load_ex   (load_ex),
    .i_rd_mem    (rd_mem),
    .i_rf_en_mem (rf_en_mem),
    .i_rd_wb     (rd_wb),
    .i_rf_en_wb  (rf_en_wb),
    .o_fwd       (w_fwd_a)
  );

  fwd_select u_fwd_rm (
    .i_src       (rm_id),
    .i_use       (use_rm),
    .i_rd_ex     (rd_ex),
    .i_rf_en_ex  (rf_en_ex),
    .i_load_ex   (load_ex),
    .i_rd_mem    (rd_mem),
    .i_rf_en_mem (rf_en_mem),
    .i_rd_wb     (rd_wb),
    .i_rf_en_wb  (rf_en_wb),
    .o_fwd       (w_fwd_b)
  );

  fwd_select u_fwd_rd (
    .i_src       (rd_id),
    .i_use       (use_rd),
    .i_rd_ex     (rd_ex),
    .i_rf_en_ex  (rf_en_ex),
    .i_load_ex   (load_ex),
    .i_rd_mem    (rd_mem),
    .i_rf_en_mem (rf_en_mem),
    .i_rd_wb     (rd_wb),
    .i_rf_en_wb  (rf_en_wb),
    .o_fwd       (w_fwd_c)
  );

  assign fwd_a = reset ? FWD_RF : w_fwd_a;
  assign fwd_b = reset ? FWD_RF : w_fwd_b;
  assign fwd_c = reset ? FWD_RF : w_fwd_c;

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;
  logic        w_enter_stall;
  logic        w_enter_flush;

  assign w_enter_stall = (w_next == ST_LDSTALL) && (r_state != ST_LDSTALL);
  assign w_enter_flush = (w_next == ST_BFLUSH) && (r_state != ST_BFLUSH);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_enter_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_enter_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios then random traffic
// compared against a behavioural model of the stall/flush/forwarding rules.
module tb_pipeline_hazard_ctrl;

`ifdef HAZ_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rn_id, rm_id, rd_id;
  logic        use_rn, use_rm, use_rd;
  logic [3:0]  rd_ex, rd_mem, rd_wb;
  logic        rf_en_ex, rf_en_mem, rf_en_wb;
  logic        load_ex, branch_taken_id, hold_req;
  logic        pc_le, ifid_le, nop_sel;
  logic [1:0]  fwd_a, fwd_b, fwd_c;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // Model: "release" = cycle after a load-use bubble; "squash" = cycle after a taken branch.
  bit m_release;
  bit m_squash;
  int m_stalls;
  int m_flushes;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .rn_id(rn_id), .rm_id(rm_id), .rd_id(rd_id),
    .use_rn(use_rn), .use_rm(use_rm), .use_rd(use_rd),
    .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
    .rf_en_ex(rf_en_ex), .rf_en_mem(rf_en_mem), .rf_en_wb(rf_en_wb),
    .load_ex(load_ex), .branch_taken_id(branch_taken_id), .hold_req(hold_req),
    .pc_le(pc_le), .ifid_le(ifid_le), .nop_sel(nop_sel),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic bit ref_load_use();
    if (!(load_ex && rf_en_ex && rd_ex != 4'd15)) return 1'b0;
    return (use_rn && rn_id == rd_ex) || (use_rm && rm_id == rd_ex) ||
           (use_rd && rd_id == rd_ex);
  endfunction

  function automatic logic [1:0] ref_fwd(input logic u, input logic [3:0] src);
    logic [3:0] dst [3];
    logic       en  [3];
    if (reset) return 2'd0;
    dst[0] = rd_ex;  en[0] = rf_en_ex && !load_ex;
    dst[1] = rd_mem; en[1] = rf_en_mem;
    dst[2] = rd_wb;  en[2] = rf_en_wb;
    for (int k = 0; k < 3; k++)
      if (u && en[k] && dst[k] == src && src != 4'd15) return 2'(k + 1);
    return 2'd0;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Combinational outputs are checked mid-cycle against the model.
  task automatic eval();
    logic [2:0] e;
    #2;
    if (reset)               e = 3'b110;
    else if (hold_req)       e = 3'b000;
    else if (m_squash)       e = 3'b111;
    else if (m_release)      e = 3'b110;
    else if (ref_load_use()) e = 3'b001;
    else                     e = 3'b110;
    chk("pc_le",   {15'd0, pc_le},   {15'd0, e[2]});
    chk("ifid_le", {15'd0, ifid_le}, {15'd0, e[1]});
    chk("nop_sel", {15'd0, nop_sel}, {15'd0, e[0]});
    chk("fwd_a", {14'd0, fwd_a}, {14'd0, ref_fwd(use_rn, rn_id)});
    chk("fwd_b", {14'd0, fwd_b}, {14'd0, ref_fwd(use_rm, rm_id)});
    chk("fwd_c", {14'd0, fwd_c}, {14'd0, ref_fwd(use_rd, rd_id)});
    chk("stall_cnt", stall_cnt, CNT_EN ? 16'(m_stalls) : 16'd0);
    chk("flush_cnt", flush_cnt, CNT_EN ? 16'(m_flushes) : 16'd0);
  endtask

  task automatic tick();
    bit lu;
    lu = ref_load_use();
    @(posedge clk);
    if (reset) begin
      m_release = 0; m_squash = 0; m_stalls = 0; m_flushes = 0;
    end else if (!hold_req) begin
      if (m_squash) m_squash = 0;
      else if (m_release) begin
        m_release = 0;
        if (branch_taken_id) begin m_squash = 1; if (m_flushes < 65535) m_flushes++; end
      end else if (lu) begin
        m_release = 1; if (m_stalls < 65535) m_stalls++;
      end else if (branch_taken_id) begin
        m_squash = 1; if (m_flushes < 65535) m_flushes++;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    rn_id = 0; rm_id = 0; rd_id = 0; use_rn = 0; use_rm = 0; use_rd = 0;
    rd_ex = 0; rd_mem = 0; rd_wb = 0; rf_en_ex = 0; rf_en_mem = 0; rf_en_wb = 0;
    load_ex = 0; branch_taken_id = 0; hold_req = 0;
  endtask

  function automatic logic [3:0] rnd_reg();
    return ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
  endfunction

  initial begin
    idle_inputs();
    reset = 1;
    m_release = 0; m_squash = 0; m_stalls = 0; m_flushes = 0;
    @(posedge clk); #1;
    eval(); tick();
    reset = 0;
    eval(); tick();

    // Load-use on Rn: bubble, then release with MEM forwarding.
    load_ex = 1; rd_ex = 3; rf_en_ex = 1; rn_id = 3; use_rn = 1;
    eval();
    chk("lu_c0_pc", {15'd0, pc_le}, 16'd0);
    chk("lu_c0_nop", {15'd0, nop_sel}, 16'd1);
    tick();
    load_ex = 0; rf_en_ex = 0; rd_ex = 0; rd_mem = 3; rf_en_mem = 1;
    eval();
    chk("lu_c1_en", {14'd0, pc_le, ifid_le}, 16'd3);
    chk("lu_c1_fwd_a", {14'd0, fwd_a}, 16'd2);
    chk("lu_c1_stall", stall_cnt, CNT_EN ? 16'd1 : 16'd0);
    tick();
    idle_inputs();

    // Taken branch: squash next cycle, then back to normal.
    branch_taken_id = 1;
    eval(); tick();
    branch_taken_id = 0;
    eval();
    chk("br_nop", {15'd0, nop_sel}, 16'd1);
    chk("br_flush", flush_cnt, CNT_EN ? 16'd1 : 16'd0);
    tick();
    eval();
    chk("br_run_nop", {15'd0, nop_sel}, 16'd0);
    tick();

    // Forwarding priority.
    rd_ex = 5; rd_mem = 5; rd_wb = 5; rf_en_ex = 1; rf_en_mem = 1; rf_en_wb = 1;
    rm_id = 5; use_rm = 1; rd_id = 15; use_rd = 1;
    eval();
    chk("fwd_b_ex", {14'd0, fwd_b}, 16'd1);
    chk("fwd_c_pc", {14'd0, fwd_c}, 16'd0);
    rf_en_ex = 0;
    eval();
    chk("fwd_b_mem", {14'd0, fwd_b}, 16'd2);
    rf_en_mem = 0;
    eval();
    chk("fwd_b_wb", {14'd0, fwd_b}, 16'd3);
    tick();
    idle_inputs();

    // Load-use and branch together, then hold during the release cycle.
    load_ex = 1; rf_en_ex = 1; rd_ex = 7; rm_id = 7; use_rm = 1; branch_taken_id = 1;
    eval(); tick();
    load_ex = 0; rf_en_ex = 0; hold_req = 1;
    eval();
    chk("hold_en", {13'd0, pc_le, ifid_le, nop_sel}, 16'd0);
    tick();
    eval(); tick();
    hold_req = 0;
    eval(); tick();
    branch_taken_id = 0;
    eval();
    chk("ldbr_squash", {15'd0, nop_sel}, 16'd1);
    tick();
    idle_inputs();

    // Reset while squashing.
    branch_taken_id = 1;
    eval(); tick();
    branch_taken_id = 0; reset = 1;
    eval(); tick();
    reset = 0;
    eval();
    chk("rst_nop", {15'd0, nop_sel}, 16'd0);
    chk("rst_stall", stall_cnt, 16'd0);
    chk("rst_flush", flush_cnt, 16'd0);
    tick();

    // Ten load-use stalls.
    for (int i = 0; i < 10; i++) begin
      load_ex = 1; rf_en_ex = 1; rd_ex = 2; rn_id = 2; use_rn = 1;
      eval(); tick();
      idle_inputs();
      eval(); tick();
    end
    chk("stall10", stall_cnt, CNT_EN ? 16'd10 : 16'd0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      rn_id = rnd_reg(); rm_id = rnd_reg(); rd_id = rnd_reg();
      rd_ex = rnd_reg(); rd_mem = rnd_reg(); rd_wb = rnd_reg();
      use_rn = 1'($urandom); use_rm = 1'($urandom); use_rd = 1'($urandom);
      rf_en_ex = 1'($urandom); rf_en_mem = 1'($urandom); rf_en_wb = 1'($urandom);
      load_ex = ($urandom_range(0, 9) < 4);
      branch_taken_id = ($urandom_range(0, 9) < 2);
      hold_req = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 49) == 0);
      eval(); tick();
    end
    reset = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
